// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM step scheduler.
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_RUN       = 3'd2,
    ST_GATE_GO   = 3'd3,
    ST_GATE_WAIT = 3'd4,
    ST_CLEAR     = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  localparam logic GRANT_AX = 1'b0;
  localparam logic GRANT_AH = 1'b1;

  localparam int SEQ_LEN_DEF = 100;

  // Step counter width; a one-step sequence still needs a 1-bit counter port.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lstm_wbus_arb.sv
// Two-way round-robin arbiter for the shared weight-read bus.
// A grant is kept for as long as its holder keeps requesting; ties go to
// whichever side did not hold the bus last.
module lstm_wbus_arb
  import lstm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic ax_req_i,
  input  logic ah_req_i,
  output logic ax_hold_o,
  output logic ah_hold_o,
  output logic wbus_sel_o
);

  logic gnt_vld_q, gnt_vld_d;
  logic gnt_who_q, gnt_who_d;
  logic last_q, last_d;
  logic holder_req;
  logic gnt_ax, gnt_ah;

  assign holder_req = (gnt_who_q == GRANT_AX) ? ax_req_i : ah_req_i;

  // Next grant: hold while the owner requests, otherwise re-arbitrate.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_who_d = gnt_who_q;
    last_d    = last_q;
    if (en_i) begin
      if (gnt_vld_q && holder_req) begin
        gnt_vld_d = 1'b1;
      end else if (ax_req_i && ah_req_i) begin
        gnt_vld_d = 1'b1;
        gnt_who_d = ~last_q;
      end else if (ax_req_i) begin
        gnt_vld_d = 1'b1;
        gnt_who_d = GRANT_AX;
      end else if (ah_req_i) begin
        gnt_vld_d = 1'b1;
        gnt_who_d = GRANT_AH;
      end
      if (gnt_vld_d) last_d = gnt_who_d;
    end
  end

  // Grant registers; after reset ah counts as last holder so ax wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_vld_q <= 1'b0;
      gnt_who_q <= GRANT_AX;
      last_q    <= GRANT_AH;
    end else begin
      gnt_vld_q <= gnt_vld_d;
      gnt_who_q <= gnt_who_d;
      last_q    <= last_d;
    end
  end

  // Gating with en_i keeps the bus released the moment the scheduler leaves RUN.
  assign gnt_ax     = en_i & gnt_vld_q & (gnt_who_q == GRANT_AX);
  assign gnt_ah     = en_i & gnt_vld_q & (gnt_who_q == GRANT_AH);
  assign ax_hold_o  = ~gnt_ax;
  assign ah_hold_o  = ~gnt_ah;
  assign wbus_sel_o = gnt_ah;

endmodule

// File: rtl/lstm_step_sched.sv
// Per-timestep sequencer for one LSTM layer: launches the ax/ah engines,
// arbitrates their weight bus, kicks the gate stage and re-arms the engines.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | waiting for step_req (blocked while err is set)
//   LAUNCH     | raise engine starts, clear or preset done flags
//   RUN        | engines computing; collect finishes, watchdog running
//   GATE_GO    | one-cycle gate_start pulse
//   GATE_WAIT  | waiting for gate_finish, watchdog running
//   CLEAR      | new_cal pulse; goes to IDLE when abandoning the step
//   DONE       | step_done (and seq_done on last step), advance step_cnt
module lstm_step_sched
  import lstm_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter bit SKIP_H0 = 1'b1,
  parameter int TO_W    = 24,
  localparam int CW     = cnt_width(SEQ_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          step_req_i,
  input  logic          abort_i,
  output logic          ax_start_o,
  input  logic          ax_rd_req_i,
  input  logic          ax_finish_i,
  output logic          ah_start_o,
  input  logic          ah_rd_req_i,
  input  logic          ah_finish_i,
  output logic          ax_hold_o,
  output logic          ah_hold_o,
  output logic          wbus_sel_o,
  output logic          gate_start_o,
  input  logic          gate_finish_i,
  output logic          new_cal_o,
  output logic          step_done_o,
  output logic          seq_done_o,
  output logic [CW-1:0] step_cnt_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [CW-1:0] LAST_STEP = CW'(SEQ_LEN - 1);

  state_e            state_q, state_d;
  logic              ax_start_q, ax_start_d;
  logic              ah_start_q, ah_start_d;
  logic              ax_done_q, ax_done_d;
  logic              ah_done_q, ah_done_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              abandon_q, abandon_d;
  logic              wd_tc;

  assign wd_tc = &wd_q;

  // Next-state logic for the FSM, engine starts, done flags, watchdog and step counter.
  always_comb begin
    state_d    = state_q;
    ax_start_d = ax_start_q;
    ah_start_d = ah_start_q;
    ax_done_d  = ax_done_q;
    ah_done_d  = ah_done_q;
    wd_d       = wd_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    abandon_d  = abandon_q;

    case (state_q)
      ST_IDLE: begin
        if (step_req_i && !err_q) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        ax_start_d = 1'b1;
        ax_done_d  = 1'b0;
        // h0 is zero on the first step, so the ah result is known without running it.
        if (SKIP_H0 && (cnt_q == '0)) begin
          ah_start_d = 1'b0;
          ah_done_d  = 1'b1;
        end else begin
          ah_start_d = 1'b1;
          ah_done_d  = 1'b0;
        end
        abandon_d = 1'b0;
        wd_d      = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (ax_finish_i) ax_done_d = 1'b1;
        if (ah_finish_i) ah_done_d = 1'b1;
        if (ax_done_q)   ax_start_d = 1'b0;
        if (ah_done_q)   ah_start_d = 1'b0;
        if (wd_tc) begin
          err_d      = 1'b1;
          abandon_d  = 1'b1;
          ax_start_d = 1'b0;
          ah_start_d = 1'b0;
          state_d    = ST_CLEAR;
        end else begin
          wd_d = wd_q + TO_W'(1);
          if (ax_done_q && ah_done_q) state_d = ST_GATE_GO;
        end
      end
      ST_GATE_GO: begin
        wd_d    = '0;
        state_d = ST_GATE_WAIT;
      end
      ST_GATE_WAIT: begin
        if (wd_tc) begin
          err_d     = 1'b1;
          abandon_d = 1'b1;
          state_d   = ST_CLEAR;
        end else begin
          wd_d = wd_q + TO_W'(1);
          if (gate_finish_i) state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ax_start_d = 1'b0;
        ah_start_d = 1'b0;
        abandon_d  = 1'b0;
        state_d    = abandon_q ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        cnt_d   = (cnt_q == LAST_STEP) ? '0 : cnt_q + CW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every other event.
    if (abort_i) begin
      err_d = 1'b0;
      cnt_d = '0;
      if (state_q != ST_IDLE) begin
        state_d    = ST_CLEAR;
        abandon_d  = 1'b1;
        ax_start_d = 1'b0;
        ah_start_d = 1'b0;
        ax_done_d  = 1'b0;
        ah_done_d  = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ax_start_q <= 1'b0;
      ah_start_q <= 1'b0;
      ax_done_q  <= 1'b0;
      ah_done_q  <= 1'b0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      abandon_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ax_start_q <= ax_start_d;
      ah_start_q <= ah_start_d;
      ax_done_q  <= ax_done_d;
      ah_done_q  <= ah_done_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      abandon_q  <= abandon_d;
    end
  end

  lstm_wbus_arb u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (state_q == ST_RUN),
    .ax_req_i   (ax_rd_req_i),
    .ah_req_i   (ah_rd_req_i),
    .ax_hold_o  (ax_hold_o),
    .ah_hold_o  (ah_hold_o),
    .wbus_sel_o (wbus_sel_o)
  );

  assign ax_start_o   = ax_start_q;
  assign ah_start_o   = ah_start_q;
  assign gate_start_o = (state_q == ST_GATE_GO);
  assign new_cal_o    = (state_q == ST_CLEAR);
  assign step_done_o  = (state_q == ST_DONE);
  assign seq_done_o   = (state_q == ST_DONE) && (cnt_q == LAST_STEP);
  assign step_cnt_o   = cnt_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_lstm_step_sched.sv
// Bench for lstm_step_sched with SEQ_LEN=3, SKIP_H0=1, TO_W=6.
module tb_lstm_step_sched;

  localparam int SEQ_LEN = 3;
  localparam int CW      = 2;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_req = 1'b0, abort = 1'b0;
  logic ax_rd_req = 1'b0, ah_rd_req = 1'b0;
  logic ax_finish = 1'b0, ah_finish = 1'b0, gate_finish = 1'b0;
  logic ax_start, ah_start, ax_hold, ah_hold, wbus_sel;
  logic gate_start, new_cal, step_done, seq_done, busy, err;
  logic [CW-1:0] step_cnt;

  int n_vec = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t exp_e;
  int   tb_cnt = 0;

  bit            ok, gd, sah, bg;
  int            lat, gsd, ncc, sdc, erc, gfc;
  logic [CW-1:0] gc;
  logic          gq;

  always #5 clk = ~clk;

  lstm_step_sched #(.SEQ_LEN(SEQ_LEN), .SKIP_H0(1'b1), .TO_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .step_req_i(step_req), .abort_i(abort),
    .ax_start_o(ax_start), .ax_rd_req_i(ax_rd_req), .ax_finish_i(ax_finish),
    .ah_start_o(ah_start), .ah_rd_req_i(ah_rd_req), .ah_finish_i(ah_finish),
    .ax_hold_o(ax_hold), .ah_hold_o(ah_hold), .wbus_sel_o(wbus_sel),
    .gate_start_o(gate_start), .gate_finish_i(gate_finish), .new_cal_o(new_cal),
    .step_done_o(step_done), .seq_done_o(seq_done), .step_cnt_o(step_cnt),
    .busy_o(busy), .err_o(err)
  );

  // Expected step_done record for the next step, from the bench's own counter.
  task automatic push_exp();
    exp_t e;
    e.cnt = CW'(tb_cnt);
    e.seq = (tb_cnt == SEQ_LEN - 1);
    exp_q.push_back(e);
    tb_cnt = (tb_cnt == SEQ_LEN - 1) ? 0 : tb_cnt + 1;
  endtask

  // Pulse step_req and wait (bounded) for ax_start; returns at that negedge.
  task automatic start_step(output bit ok_o, output int lat_o);
    ok_o = 0; lat_o = -1;
    @(negedge clk); step_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) step_req = 1'b0;
      if (ax_start) begin ok_o = 1; lat_o = c; break; end
    end
    step_req = 1'b0;
  endtask

  // Engine/gate responder from the first RUN cycle until step_done or return to IDLE.
  task automatic complete_step(input int ax_lat, input int ah_lat, input int gate_lat, input int max_cyc,
                               output bit got_done, output logic [CW-1:0] got_cnt, output logic got_seq,
                               output bit saw_ah, output int gs_dly, output int nc_cyc, output int sd_cyc,
                               output int err_cyc, output int gf_cyc, output bit both_gnt);
    int fin_cyc;
    int gcnt;
    got_done = 0; got_cnt = '0; got_seq = 1'b0; saw_ah = 0; gs_dly = -1; nc_cyc = -1;
    sd_cyc = -1; err_cyc = -1; gf_cyc = -1; both_gnt = 0; fin_cyc = -1; gcnt = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) @(negedge clk);
      gate_finish = 1'b0;
      if (ah_start) saw_ah = 1;
      if (!ax_hold && !ah_hold) both_gnt = 1;
      if (err && err_cyc < 0) err_cyc = c;
      if (gate_start && gs_dly < 0) begin
        gs_dly = c - fin_cyc; gcnt = gate_lat;
      end else if (gcnt > 0) begin
        gcnt--;
        if (gcnt == 0) begin gate_finish = 1'b1; gf_cyc = c; end
      end
      if (new_cal) begin nc_cyc = c; ax_finish = 1'b0; ah_finish = 1'b0; end
      if (step_done) begin
        got_done = 1; got_cnt = step_cnt; got_seq = seq_done; sd_cyc = c; break;
      end
      if (nc_cyc >= 0 && !busy) break;
      if (nc_cyc < 0) begin
        if (c == ax_lat) begin ax_finish = 1'b1; fin_cyc = c; end
        if (ah_lat >= 0 && c == ah_lat) begin ah_finish = 1'b1; fin_cyc = c; end
      end
    end
    gate_finish = 1'b0; ax_finish = 1'b0; ah_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, ax_start, ah_start, gate_start, new_cal, step_done, seq_done, err, wbus_sel} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 000000000",
               {busy, ax_start, ah_start, gate_start, new_cal, step_done, seq_done, err, wbus_sel});
    end
    n_vec++;
    if (step_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", step_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_sequence();
    for (int s = 0; s < 3; s++) begin
      push_exp();
      start_step(ok, lat);
      n_vec++;
      if (!ok || lat != 2) begin n_bad++; $display("FAIL seq_launch_lat s%0d: got %0d want 2", s, lat); end
      complete_step(3 + s, (s == 0) ? -1 : 4, 5, 80, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
      n_vec++;
      if (sah !== (s != 0)) begin n_bad++; $display("FAIL seq_ah_start s%0d: got %b want %b", s, sah, (s != 0)); end
      n_vec++;
      if (gfc < 0 || ncc != gfc + 1) begin n_bad++; $display("FAIL seq_newcal s%0d: got %0d want %0d", s, ncc, gfc + 1); end
      exp_e = exp_q.pop_front();
      n_vec++;
      if (!gd || gc !== exp_e.cnt || gq !== exp_e.seq) begin
        n_bad++;
        $display("FAIL seq_sb s%0d: done=%b cnt=%0d seq=%b want cnt=%0d seq=%b", s, gd, gc, gq, exp_e.cnt, exp_e.seq);
      end
    end
    @(negedge clk);
    n_vec++;
    if (step_cnt !== 2'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL seq_wrap: cnt=%0d busy=%b want cnt=0 busy=0", step_cnt, busy);
    end
  endtask

  task automatic test_arb_tie();
    push_exp();
    start_step(ok, lat);
    ax_rd_req = 1'b1; ah_rd_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ax_hold, ah_hold, wbus_sel} !== 3'b010) begin
      n_bad++; $display("FAIL tie_first: hold/sel got %b want 010", {ax_hold, ah_hold, wbus_sel});
    end
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ax_hold, ah_hold, wbus_sel} !== 3'b010) begin
        n_bad++; $display("FAIL tie_keep c%0d: got %b want 010", i, {ax_hold, ah_hold, wbus_sel});
      end
    end
    ax_rd_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ax_hold, ah_hold, wbus_sel} !== 3'b101) begin
      n_bad++; $display("FAIL tie_handover: got %b want 101", {ax_hold, ah_hold, wbus_sel});
    end
    ah_rd_req = 1'b0;
    complete_step(0, -1, 2, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    exp_e = exp_q.pop_front();
    n_vec++;
    if (!gd || gc !== exp_e.cnt || gq !== exp_e.seq) begin
      n_bad++; $display("FAIL tie_sb: done=%b cnt=%0d seq=%b want cnt=%0d seq=%b", gd, gc, gq, exp_e.cnt, exp_e.seq);
    end
  endtask

  task automatic test_arb_hold();
    push_exp();
    start_step(ok, lat);
    ax_rd_req = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1) ah_rd_req = 1'b1;
      n_vec++;
      if ({ax_hold, ah_hold, wbus_sel} !== 3'b010) begin
        n_bad++; $display("FAIL hold_keep c%0d: got %b want 010", i, {ax_hold, ah_hold, wbus_sel});
      end
    end
    ax_rd_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ax_hold, ah_hold, wbus_sel} !== 3'b101) begin
      n_bad++; $display("FAIL hold_release: got %b want 101", {ax_hold, ah_hold, wbus_sel});
    end
    ah_rd_req = 1'b0;
    complete_step(0, 0, 1, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    exp_e = exp_q.pop_front();
    n_vec++;
    if (!gd || gc !== exp_e.cnt || gq !== exp_e.seq) begin
      n_bad++; $display("FAIL hold_sb: done=%b cnt=%0d seq=%b want cnt=%0d seq=%b", gd, gc, gq, exp_e.cnt, exp_e.seq);
    end
  endtask

  task automatic test_simul_finish();
    push_exp();
    start_step(ok, lat);
    complete_step(3, 3, 3, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    n_vec++;
    if (gsd != 2) begin n_bad++; $display("FAIL simul_gate_lat: got %0d want 2", gsd); end
    n_vec++;
    if (gfc < 0 || ncc != gfc + 1 || sdc != ncc + 1) begin
      n_bad++; $display("FAIL simul_order: gf=%0d nc=%0d sd=%0d want nc=gf+1 sd=nc+1", gfc, ncc, sdc);
    end
    exp_e = exp_q.pop_front();
    n_vec++;
    if (!gd || gc !== exp_e.cnt || gq !== exp_e.seq) begin
      n_bad++; $display("FAIL simul_sb: done=%b cnt=%0d seq=%b want cnt=%0d seq=%b", gd, gc, gq, exp_e.cnt, exp_e.seq);
    end
  endtask

  task automatic test_timeout();
    push_exp();
    start_step(ok, lat);
    complete_step(1, -1, 1, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    exp_e = exp_q.pop_front();
    n_vec++;
    if (!gd || gc !== exp_e.cnt || gq !== exp_e.seq) begin
      n_bad++; $display("FAIL to_pre_sb: done=%b cnt=%0d want cnt=%0d", gd, gc, exp_e.cnt);
    end
    start_step(ok, lat);
    complete_step(2, -1, 1, 150, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    n_vec++;
    if (erc < 63 || erc > 64) begin n_bad++; $display("FAIL to_err_cycle: got %0d want 63..64", erc); end
    n_vec++;
    if (ncc != erc || gd) begin n_bad++; $display("FAIL to_newcal: nc=%0d done=%b want nc=%0d done=0", ncc, gd, erc); end
    @(negedge clk);
    n_vec++;
    if ({err, busy} !== 2'b10 || step_cnt !== 2'd1) begin
      n_bad++; $display("FAIL to_state: err/busy=%b cnt=%0d want 10 cnt=1", {err, busy}, step_cnt);
    end
    start_step(ok, lat);
    n_vec++;
    if (ok || busy !== 1'b0) begin n_bad++; $display("FAIL to_blocked: started=%b busy=%b want 0 0", ok, busy); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_vec++;
    if (err !== 1'b0 || step_cnt !== 2'd0) begin
      n_bad++; $display("FAIL to_abort_idle: err=%b cnt=%0d want 0 0", err, step_cnt);
    end
    tb_cnt = 0;
  endtask

  task automatic test_abort_reset();
    push_exp();
    start_step(ok, lat);
    complete_step(1, -1, 1, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    exp_e = exp_q.pop_front();
    n_vec++;
    if (!gd || gc !== exp_e.cnt) begin n_bad++; $display("FAIL ab_pre_sb: done=%b cnt=%0d want cnt=%0d", gd, gc, exp_e.cnt); end
    start_step(ok, lat);
    ax_rd_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ax_hold !== 1'b0) begin n_bad++; $display("FAIL ab_grant: ax_hold=%b want 0", ax_hold); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; ax_rd_req = 1'b0;
    n_vec++;
    if ({busy, new_cal, ax_start, ah_start, ax_hold} !== 5'b11001) begin
      n_bad++; $display("FAIL ab_clear: got %b want 11001", {busy, new_cal, ax_start, ah_start, ax_hold});
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || step_cnt !== 2'd0 || err !== 1'b0) begin
      n_bad++; $display("FAIL ab_idle: busy=%b cnt=%0d err=%b want 0 0 0", busy, step_cnt, err);
    end
    tb_cnt = 0;
    push_exp();
    start_step(ok, lat);
    complete_step(1, -1, 1, 40, gd, gc, gq, sah, gsd, ncc, sdc, erc, gfc, bg);
    exp_e = exp_q.pop_front();
    start_step(ok, lat);
    ax_finish = 1'b1; ah_finish = 1'b1;
    ok = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gate_start) begin ok = 1; break; end
    end
    @(negedge clk);
    n_vec++;
    if (!ok || busy !== 1'b1 || step_cnt !== 2'd1) begin
      n_bad++; $display("FAIL rst_pre: gate_seen=%b busy=%b cnt=%0d want 1 1 1", ok, busy, step_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, ax_start, ah_start, gate_start, new_cal, step_done, seq_done, err, wbus_sel, step_cnt} !== 11'b0) begin
      n_bad++;
      $display("FAIL rst_async: got %b want 0", {busy, ax_start, ah_start, gate_start, new_cal, step_done, seq_done, err, wbus_sel, step_cnt});
    end
    ax_finish = 1'b0; ah_finish = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_arb_tie();
    test_arb_hold();
    test_simul_finish();
    test_timeout();
    test_abort_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
